// File: rtl/pll_sup_pkg.sv
// Shared types for the PLL lock supervisor: state encodings, counter widths,
// and the saturating increment used by the lock-loss counter.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_RST_PLL   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } sup_state_e;

  localparam int CNT_W_DEF = 16;
  localparam int LOSS_W    = 8;
  localparam int RETRY_W   = 2;

  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Purpose: two-flop synchronizer for asynchronous status bits, resets to 0.
// Latency: 2 clk cycles from input change to dout.
// Backpressure: none; samples every cycle.
module pll_lock_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      dout <= '0;
    end else begin
      meta <= din;
      dout <= meta;
    end
  end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Purpose: sequences PLL reset, waits for lock with timeout/retries, qualifies lock, gates system reset.
// Latency: pll_locked acts 2 refclk cycles after it changes (sync); every output is registered.
// Backpressure: none; relock_req is a single-cycle pulse that is always accepted.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int GLITCH_CYCLES = 4,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic               refclk,
  input  logic               rst,
  input  logic               pll_locked,
  input  logic               relock_req,
  output logic               pll_rst,
  output logic               sys_rst_n,
  output logic               ready,
  output logic               fault,
  output logic [2:0]         state_o,
  output logic [RETRY_W-1:0] retry_cnt,
  output logic [LOSS_W-1:0]  loss_cnt
);

  if (CNT_W < 2 || CNT_W > 30) begin : g_bad_cnt_w
    $error("CNT_W must be in 2..30");
  end
  if (RST_CYCLES < 1 || RST_CYCLES > (1 << CNT_W)) begin : g_bad_rst_cycles
    $error("RST_CYCLES must be in 1..2**CNT_W");
  end
  if (LOCK_TIMEOUT < 1 || LOCK_TIMEOUT > (1 << CNT_W)) begin : g_bad_lock_timeout
    $error("LOCK_TIMEOUT must be in 1..2**CNT_W");
  end
  if (STABLE_CYCLES < 1 || STABLE_CYCLES > (1 << CNT_W)) begin : g_bad_stable_cycles
    $error("STABLE_CYCLES must be in 1..2**CNT_W");
  end
  if (GLITCH_CYCLES < 1 || GLITCH_CYCLES >= (1 << CNT_W)) begin : g_bad_glitch_cycles
    $error("GLITCH_CYCLES must be in 1..2**CNT_W-1");
  end
  if (MAX_RETRIES < 1 || MAX_RETRIES > (1 << RETRY_W) - 1) begin : g_bad_max_retries
    $error("MAX_RETRIES does not fit retry_cnt");
  end

  localparam logic [CNT_W-1:0]   CNT_ONE      = CNT_W'(1);
  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   GLITCH_LIM   = CNT_W'(GLITCH_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_ONE    = RETRY_W'(1);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  sup_state_e         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [CNT_W-1:0]   glitch_q, glitch_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [LOSS_W-1:0]  loss_q, loss_d;
  logic               lk;

  pll_lock_sync #(.WIDTH(1)) u_lock_sync (
    .clk   (refclk),
    .rst_n (rst),
    .din   (pll_locked),
    .dout  (lk)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    glitch_d = '0;
    retry_d  = retry_q;
    loss_d   = loss_q;
    if (relock_req) begin
      state_d = ST_RST_PLL;
      cnt_d   = '0;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_RST_PLL: begin
          if (cnt_q == RST_LAST) begin
            state_d = ST_WAIT_LOCK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_WAIT_LOCK: begin
          // lock seen on the timeout cycle still counts as acquired
          if (lk) begin
            state_d = ST_STABLE;
            cnt_d   = '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            retry_d = retry_q + RETRY_ONE;
            cnt_d   = '0;
            state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_RST_PLL;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_STABLE: begin
          if (!lk) begin
            cnt_d = '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            retry_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_RUN: begin
          if (!lk) begin
            if (glitch_q + CNT_ONE == GLITCH_LIM) begin
              loss_d  = sat_inc_loss(loss_q);
              state_d = ST_RST_PLL;
              cnt_d   = '0;
            end else begin
              glitch_d = glitch_q + CNT_ONE;
            end
          end
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_RST_PLL;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs are registered from the next state so they change on the same edge as state_q.
  always_ff @(posedge refclk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_RST_PLL;
      cnt_q     <= '0;
      glitch_q  <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst   <= 1'b1;
      sys_rst_n <= 1'b0;
      ready     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      glitch_q  <= glitch_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst   <= (state_d == ST_RST_PLL) || (state_d == ST_FAULT);
      sys_rst_n <= (state_d == ST_RUN);
      ready     <= (state_d == ST_RUN);
      fault     <= (state_d == ST_FAULT);
    end
  end

  assign state_o   = state_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Bench for pll_lock_supervisor with shortened timeout/qualification windows.
// A monitor pops expected state transitions (state, cycle) as the DUT changes state.
module tb_pll_lock_supervisor;

  localparam int P_RST = 16;
  localparam int P_TO  = 400;
  localparam int P_STB = 64;
  localparam int P_GL  = 4;
  localparam int P_MR  = 3;
  localparam int TOG   = 40;

  localparam logic [2:0] S_RST   = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_STB   = 3'd2;
  localparam logic [2:0] S_RUN   = 3'd3;
  localparam logic [2:0] S_FAULT = 3'd4;

  logic       refclk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, ready, fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [2:0] st;
    int         cyc;
  } exp_t;

  exp_t       sb_q[$];
  exp_t       mon_e;
  logic [2:0] prev_state = 3'd0;
  bit         mon_en = 1'b0;

  pll_lock_supervisor #(
    .RST_CYCLES    (P_RST),
    .LOCK_TIMEOUT  (P_TO),
    .STABLE_CYCLES (P_STB),
    .GLITCH_CYCLES (P_GL),
    .MAX_RETRIES   (P_MR),
    .CNT_W         (16)
  ) dut (
    .refclk     (refclk),
    .rst        (rst),
    .pll_locked (pll_locked),
    .relock_req (relock_req),
    .pll_rst    (pll_rst),
    .sys_rst_n  (sys_rst_n),
    .ready      (ready),
    .fault      (fault),
    .state_o    (state_o),
    .retry_cnt  (retry_cnt),
    .loss_cnt   (loss_cnt)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc <= cyc + 1;

  // Scoreboard monitor: every state change must match the oldest expectation.
  always @(posedge refclk) begin
    #1;
    if (mon_en && state_o !== prev_state) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected: state_o=%0d at cycle %0d, no transition expected", state_o, cyc);
      end else begin
        mon_e = sb_q.pop_front();
        if (state_o !== mon_e.st || (mon_e.cyc >= 0 && cyc != mon_e.cyc)) begin
          errors++;
          $display("FAIL sb_transition: got state %0d at cycle %0d, want state %0d at cycle %0d",
                   state_o, cyc, mon_e.st, mon_e.cyc);
        end
      end
      prev_state = state_o;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge refclk);
  endtask

  task automatic expect_st(input logic [2:0] st, input int c);
    exp_t e;
    e.st  = st;
    e.cyc = c;
    sb_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] st, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i <= budget; i++) begin
      if (state_o === st) begin
        ok = 1'b1;
        break;
      end
      @(negedge refclk);
    end
  endtask

  task automatic test_reset();
    #1 rst = 1'b0;
    tick(5);
    checks++; if (state_o !== S_RST) begin errors++; $display("FAIL rst_state: got %0d want %0d", state_o, S_RST); end
    checks++; if (pll_rst !== 1'b1) begin errors++; $display("FAIL rst_pll_rst: got %b want 1", pll_rst); end
    checks++; if (sys_rst_n !== 1'b0) begin errors++; $display("FAIL rst_sys_rst_n: got %b want 0", sys_rst_n); end
    checks++; if (ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL rst_flags: got ready=%b fault=%b want 0/0", ready, fault); end
    checks++; if (retry_cnt !== 2'd0 || loss_cnt !== 8'd0) begin errors++; $display("FAIL rst_counters: got retry=%0d loss=%0d want 0/0", retry_cnt, loss_cnt); end
    prev_state = state_o;
    mon_en = 1'b1;
  endtask

  task automatic test_power_up();
    int r, l, n, rise;
    rst = 1'b1;
    r = cyc;
    expect_st(S_WAIT, r + P_RST);
    n = 0;
    for (int i = 0; i < 200 && pll_rst === 1'b1; i++) begin
      n++;
      tick(1);
    end
    checks++; if (n != P_RST) begin errors++; $display("FAIL pu_pll_rst_width: got %0d cycles want %0d", n, P_RST); end
    tick(100);
    l = cyc;
    pll_locked = 1'b1;
    expect_st(S_STB, l + 3);
    expect_st(S_RUN, l + 3 + P_STB);
    rise = -1;
    for (int i = 0; i < P_STB + 50; i++) begin
      if (sys_rst_n === 1'b1) begin
        rise = cyc;
        break;
      end
      tick(1);
    end
    checks++;
    if (rise < l + 1 + P_STB || rise > l + 3 + P_STB) begin
      errors++; $display("FAIL pu_release_time: got cycle %0d want %0d..%0d", rise, l + 1 + P_STB, l + 3 + P_STB);
    end
    checks++; if (ready !== 1'b1 || state_o !== S_RUN) begin errors++; $display("FAIL pu_run: got ready=%b state=%0d want 1/%0d", ready, state_o, S_RUN); end
    checks++; if (pll_rst !== 1'b0) begin errors++; $display("FAIL pu_pll_rst_low: got %b want 0", pll_rst); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL pu_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_glitch_filter();
    int e, n;
    bit ok;
    pll_locked = 1'b0;
    tick(P_GL - 1);
    pll_locked = 1'b1;
    tick(10);
    checks++; if (state_o !== S_RUN || sys_rst_n !== 1'b1) begin errors++; $display("FAIL gl_short_stay: got state=%0d sys_rst_n=%b want %0d/1", state_o, sys_rst_n, S_RUN); end
    checks++; if (loss_cnt !== 8'd0) begin errors++; $display("FAIL gl_short_loss: got %0d want 0", loss_cnt); end
    e = cyc;
    pll_locked = 1'b0;
    expect_st(S_RST, e + 6);
    expect_st(S_WAIT, e + 6 + P_RST);
    expect_st(S_STB, e + 7 + P_RST);
    expect_st(S_RUN, e + 7 + P_RST + P_STB);
    tick(P_GL);
    pll_locked = 1'b1;
    tick(2);
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL gl_loss_release: got sys_rst_n=%b ready=%b want 0/0", sys_rst_n, ready); end
    n = 0;
    for (int i = 0; i < 200 && pll_rst === 1'b1; i++) begin
      n++;
      tick(1);
    end
    checks++; if (n != P_RST) begin errors++; $display("FAIL gl_pll_rst_width: got %0d cycles want %0d", n, P_RST); end
    checks++; if (loss_cnt !== 8'd1) begin errors++; $display("FAIL gl_loss_cnt: got %0d want 1", loss_cnt); end
    wait_state(S_RUN, P_STB + 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL gl_relock: got state %0d want %0d", state_o, S_RUN); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL gl_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_timeout_vs_lock();
    int f;
    bit ok;
    f = cyc;
    pll_locked = 1'b0;
    expect_st(S_RST, f + 6);
    expect_st(S_WAIT, f + 6 + P_RST);
    expect_st(S_STB, f + 6 + P_RST + P_TO);
    expect_st(S_RUN, f + 6 + P_RST + P_TO + P_STB);
    tick(3 + P_RST + P_TO);
    pll_locked = 1'b1;
    wait_state(S_STB, 10, ok);
    checks++; if (!ok) begin errors++; $display("FAIL tvl_stable: got state %0d want %0d", state_o, S_STB); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL tvl_retry: got %0d want 0", retry_cnt); end
    wait_state(S_RUN, P_STB + 20, ok);
    checks++; if (!ok || loss_cnt !== 8'd2) begin errors++; $display("FAIL tvl_run: got state=%0d loss=%0d want %0d/2", state_o, loss_cnt, S_RUN); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL tvl_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_timeout();
    int f;
    bit ok;
    f = cyc;
    pll_locked = 1'b0;
    expect_st(S_RST, f + 6);
    expect_st(S_WAIT, f + 6 + P_RST);
    expect_st(S_RST, f + 6 + P_RST + P_TO);
    expect_st(S_WAIT, f + 6 + 2 * P_RST + P_TO);
    expect_st(S_RST, f + 6 + 2 * P_RST + 2 * P_TO);
    expect_st(S_WAIT, f + 6 + 3 * P_RST + 2 * P_TO);
    expect_st(S_FAULT, f + 6 + 3 * P_RST + 3 * P_TO);
    wait_state(S_FAULT, 3 * (P_TO + P_RST) + 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_fault_reached: got state %0d want %0d", state_o, S_FAULT); end
    checks++; if (fault !== 1'b1 || pll_rst !== 1'b1) begin errors++; $display("FAIL to_outputs: got fault=%b pll_rst=%b want 1/1", fault, pll_rst); end
    checks++; if (retry_cnt !== 2'd3) begin errors++; $display("FAIL to_retry: got %0d want 3", retry_cnt); end
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0) begin errors++; $display("FAIL to_release: got sys_rst_n=%b ready=%b want 0/0", sys_rst_n, ready); end
    tick(50);
    checks++; if (state_o !== S_FAULT || loss_cnt !== 8'd3) begin errors++; $display("FAIL to_hold: got state=%0d loss=%0d want %0d/3", state_o, loss_cnt, S_FAULT); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL to_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_recovery();
    int h;
    bit ok;
    pll_locked = 1'b1;
    tick(10);
    h = cyc;
    relock_req = 1'b1;
    expect_st(S_RST, h + 1);
    expect_st(S_WAIT, h + 1 + P_RST);
    expect_st(S_STB, h + 2 + P_RST);
    expect_st(S_RUN, h + 2 + P_RST + P_STB);
    tick(1);
    relock_req = 1'b0;
    checks++; if (fault !== 1'b0 || state_o !== S_RST) begin errors++; $display("FAIL rc_leave_fault: got fault=%b state=%0d want 0/%0d", fault, state_o, S_RST); end
    checks++; if (retry_cnt !== 2'd0 || pll_rst !== 1'b1) begin errors++; $display("FAIL rc_clear: got retry=%0d pll_rst=%b want 0/1", retry_cnt, pll_rst); end
    wait_state(S_RUN, P_RST + P_STB + 50, ok);
    checks++; if (!ok || sys_rst_n !== 1'b1) begin errors++; $display("FAIL rc_run: got state=%0d sys_rst_n=%b want %0d/1", state_o, sys_rst_n, S_RUN); end
    checks++; if (retry_cnt !== 2'd0 || loss_cnt !== 8'd3) begin errors++; $display("FAIL rc_counters: got retry=%0d loss=%0d want 0/3", retry_cnt, loss_cnt); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL rc_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_instability();
    int h, k;
    bit ok;
    h = cyc;
    relock_req = 1'b1;
    expect_st(S_RST, h + 1);
    expect_st(S_WAIT, h + 1 + P_RST);
    expect_st(S_STB, h + 2 + P_RST);
    tick(1);
    relock_req = 1'b0;
    wait_state(S_STB, P_RST + 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL in_enter_stable: got state %0d want %0d", state_o, S_STB); end
    for (int i = 0; i < 6; i++) begin
      tick(TOG);
      pll_locked = ~pll_locked;
    end
    k = cyc;
    expect_st(S_RUN, k + 2 + P_STB);
    checks++; if (state_o !== S_STB || ready !== 1'b0) begin errors++; $display("FAIL in_no_run: got state=%0d ready=%b want %0d/0", state_o, ready, S_STB); end
    checks++; if (retry_cnt !== 2'd0) begin errors++; $display("FAIL in_no_retry: got %0d want 0", retry_cnt); end
    wait_state(S_RUN, P_STB + 20, ok);
    checks++; if (!ok || loss_cnt !== 8'd3) begin errors++; $display("FAIL in_run: got state=%0d loss=%0d want %0d/3", state_o, loss_cnt, S_RUN); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL in_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  task automatic test_async_reset_and_saturation();
    int h, m, e;
    bit ok;
    h = cyc;
    relock_req = 1'b1;
    expect_st(S_RST, h + 1);
    expect_st(S_WAIT, h + 1 + P_RST);
    expect_st(S_STB, h + 2 + P_RST);
    tick(1);
    relock_req = 1'b0;
    wait_state(S_STB, P_RST + 20, ok);
    tick(10);
    expect_st(S_RST, -1);
    rst = 1'b0;
    #2;
    checks++; if (state_o !== S_RST || pll_rst !== 1'b1) begin errors++; $display("FAIL ar_state: got state=%0d pll_rst=%b want %0d/1", state_o, pll_rst, S_RST); end
    checks++; if (sys_rst_n !== 1'b0 || ready !== 1'b0 || fault !== 1'b0) begin errors++; $display("FAIL ar_flags: got sys_rst_n=%b ready=%b fault=%b want 0/0/0", sys_rst_n, ready, fault); end
    checks++; if (loss_cnt !== 8'd0 || retry_cnt !== 2'd0) begin errors++; $display("FAIL ar_counters: got loss=%0d retry=%0d want 0/0", loss_cnt, retry_cnt); end
    tick(3);
    rst = 1'b1;
    m = cyc;
    expect_st(S_WAIT, m + P_RST);
    expect_st(S_STB, m + 1 + P_RST);
    expect_st(S_RUN, m + 1 + P_RST + P_STB);
    wait_state(S_RUN, P_RST + P_STB + 50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_rerun: got state %0d want %0d", state_o, S_RUN); end
    for (int i = 0; i < 300; i++) begin
      e = cyc;
      pll_locked = 1'b0;
      expect_st(S_RST, e + 6);
      expect_st(S_WAIT, e + 6 + P_RST);
      expect_st(S_STB, e + 7 + P_RST);
      expect_st(S_RUN, e + 7 + P_RST + P_STB);
      tick(6);
      pll_locked = 1'b1;
      wait_state(S_RUN, P_RST + P_STB + 100, ok);
      checks++;
      if (!ok) begin
        errors++; $display("FAIL sat_loop: loss %0d got state %0d want %0d", i + 1, state_o, S_RUN);
        break;
      end
      if (i == 253) begin
        checks++; if (loss_cnt !== 8'd254) begin errors++; $display("FAIL sat_254: got %0d want 254", loss_cnt); end
      end
      if (i == 254) begin
        checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_255: got %0d want 255", loss_cnt); end
      end
    end
    checks++; if (loss_cnt !== 8'd255) begin errors++; $display("FAIL sat_final: got %0d want 255", loss_cnt); end
    checks++; if (sb_q.size() != 0) begin errors++; $display("FAIL sat_sb_drain: got %0d pending want 0", sb_q.size()); end
  endtask

  initial begin
    test_reset();
    test_power_up();
    test_glitch_filter();
    test_timeout_vs_lock();
    test_timeout();
    test_recovery();
    test_instability();
    test_async_reset_and_saturation();
    tick(5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
